// File: rtl/booth_seq_arbiter.sv
// booth_seq_arbiter: round-robin shared radix-2 Booth sequential multiplier with sign/magnitude result
module booth_seq_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req,
  input  logic [WIDTH-1:0]        m0,
  input  logic [WIDTH-1:0]        q0,
  input  logic [WIDTH-1:0]        m1,
  input  logic [WIDTH-1:0]        q1,
  output logic [1:0]              gnt,
  output logic                    busy,
  output logic                    done,
  output logic                    done_id,
  output logic [2*WIDTH-1:0]      product,
  output logic                    neg,
  output logic [2*WIDTH-1:0]      mag
);
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);
  state_t state, state_nxt;
  logic [WIDTH:0] a, m, sum, a_nxt;
  logic [WIDTH-1:0] q, q_nxt;
  logic r, last, id, pick;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] prod_nxt;
  always_comb begin
    pick = (&req) ? ~last : req[1];
    gnt = (state == IDLE && |req && !rst) ? (pick ? 2'b10 : 2'b01) : 2'b00;
    busy = state != IDLE;
    done = state == DONE;
    sum = ({q[0], r} == 2'b10) ? a - m : ({q[0], r} == 2'b01) ? a + m : a;
    a_nxt = {sum[WIDTH], sum[WIDTH:1]};
    q_nxt = {sum[0], q[WIDTH-1:1]};
    prod_nxt = {a_nxt[WIDTH-1:0], q_nxt};
    state_nxt = (state == IDLE) ? (|req ? ITER : IDLE) :
                (state == ITER) ? (cnt == LAST_STEP ? DONE : ITER) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last <= 1'b1;
      id <= 1'b0;
      a <= '0;
      m <= '0;
      q <= '0;
      r <= 1'b0;
      cnt <= '0;
      done_id <= 1'b0;
      product <= '0;
      neg <= 1'b0;
      mag <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && |req) begin
        m <= pick ? {m1[WIDTH-1], m1} : {m0[WIDTH-1], m0};
        q <= pick ? q1 : q0;
        a <= '0;
        r <= 1'b0;
        cnt <= '0;
        last <= pick;
        id <= pick;
      end else if (state == ITER) begin
        a <= a_nxt;
        q <= q_nxt;
        r <= q[0];
        cnt <= cnt + CW'(1);
        // results register on the final step so they are already valid in DONE
        if (cnt == LAST_STEP) begin
          product <= prod_nxt;
          neg <= prod_nxt[2*WIDTH-1];
          mag <= prod_nxt[2*WIDTH-1] ? -prod_nxt : prod_nxt;
          done_id <= id;
        end
      end
    end
  end
endmodule

// File: tb/tb_booth_seq_arbiter.sv
// tb_booth_seq_arbiter: directed vectors plus a per-cycle behavioural model of the shared multiplier
module tb_booth_seq_arbiter;
  localparam int W = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] req = 2'b00;
  logic signed [W-1:0] m0 = '0, q0 = '0, m1 = '0, q1 = '0;
  logic [1:0] gnt;
  logic busy, done, done_id, neg;
  logic [2*W-1:0] product, mag;
  int checks = 0, errors = 0;
  int mlast, rem, pend, pend_id, eprod, eid, pick, ab, lat, e, cyc, gcyc, prev_cyc;
  logic [1:0] eg;

  booth_seq_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req(req), .m0(m0), .q0(q0), .m1(m1), .q1(q1),
    .gnt(gnt), .busy(busy), .done(done), .done_id(done_id),
    .product(product), .neg(neg), .mag(mag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // model: an operation occupies WIDTH+1 cycles after its grant, the last being the done cycle
  always @(negedge clk) begin
    if (rst) begin
      mlast = 1; rem = 0; eprod = 0; eid = 0;
    end else begin
      eg = 2'b00;
      pick = 0;
      if (rem == 0 && req != 2'b00) begin
        pick = (req == 2'b11) ? (mlast == 1 ? 0 : 1) : (req[1] ? 1 : 0);
        eg = (pick == 1) ? 2'b10 : 2'b01;
      end
      if (rem == 1) begin
        eprod = pend; eid = pend_id;
      end
      ab = (eprod < 0) ? -eprod : eprod;
      chk("m_gnt", gnt, eg);
      chk("m_busy", busy, rem != 0);
      chk("m_done", done, rem == 1);
      chk("m_product", product, eprod[2*W-1:0]);
      chk("m_neg", neg, eprod < 0);
      chk("m_mag", mag, ab[2*W-1:0]);
      chk("m_done_id", done_id, eid);
      if (rem > 0) rem--;
      if (eg != 2'b00) begin
        mlast = pick;
        pend = (pick == 1) ? int'(m1) * int'(q1) : int'(m0) * int'(q0);
        pend_id = pick;
        rem = W + 1;
      end
    end
  end

  task automatic wait_gnt(input int id);
    int n = 0;
    do begin @(negedge clk); n++; end while (!gnt[id] && n < 20);
    if (!gnt[id]) timeout("gnt_wait");
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 20);
    if (!done) timeout("done_wait");
  endtask

  task automatic run_op(input int id, input logic signed [W-1:0] m, input logic signed [W-1:0] q, output int n);
    @(posedge clk); #1;
    if (id == 0) begin m0 = m; q0 = q; end else begin m1 = m; q1 = q; end
    req[id] = 1'b1;
    wait_gnt(id);
    @(posedge clk); #1 req[id] = 1'b0;
    wait_done(n);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_product", product, 0);
    chk("rst_busy", busy, 0);
    run_op(0, 4'sd3, -4'sd2, lat);
    chk("single_lat", lat, 5);
    chk("single_product", product, 8'hFA);
    chk("single_neg", neg, 1);
    chk("single_mag", mag, 6);
    chk("single_id", done_id, 0);
    run_op(1, -4'sd8, -4'sd8, lat);
    chk("corner1_product", product, 8'h40);
    chk("corner1_neg", neg, 0);
    chk("corner1_mag", mag, 64);
    chk("corner1_id", done_id, 1);
    run_op(0, -4'sd8, 4'sd7, lat);
    chk("corner2_product", product, 8'hC8);
    chk("corner2_mag", mag, 56);
    run_op(1, 4'sd0, -4'sd5, lat);
    chk("corner3_product", product, 0);
    chk("corner3_neg", neg, 0);
    // request arriving while busy waits for the IDLE cycle after done
    @(posedge clk); #1 m0 = 4'sd2; q0 = 4'sd5; req = 2'b01;
    wait_gnt(0);
    @(posedge clk); #1 req = 2'b00;
    @(posedge clk); #1 req = 2'b11; m1 = -4'sd3; q1 = 4'sd4;
    wait_done(lat);
    chk("busy_gnt_at_done", gnt, 2'b00);
    @(negedge clk);
    chk("busy_gnt_after", gnt, 2'b10);
    @(posedge clk); #1 req = 2'b00;
    wait_done(lat);
    chk("busy_product", product, 8'hF4);
    // reset during the second ITER cycle
    @(posedge clk); #1 m0 = 4'sd3; q0 = 4'sd3; req = 2'b01;
    wait_gnt(0);
    @(posedge clk); #1 req = 2'b00;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mrst_busy", busy, 0);
    chk("mrst_product", product, 0);
    chk("mrst_mag", mag, 0);
    repeat (6) begin @(negedge clk); chk("mrst_no_done", done, 0); end
    @(posedge clk); #1 req = 2'b11;
    @(negedge clk);
    chk("mrst_tie", gnt, 2'b01);
    @(posedge clk); #1 req = 2'b00;
    wait_done(lat);
    // contention from reset
    @(posedge clk); #1 rst = 1'b1; req = 2'b11; m0 = 4'sd2; q0 = 4'sd3; m1 = -4'sd4; q1 = 4'sd5;
    @(posedge clk); #1 rst = 1'b0;
    prev_cyc = 0;
    for (int k = 0; k < 4; k++) begin
      int n = 0;
      do begin @(negedge clk); n++; end while (gnt == 2'b00 && n < 20);
      if (gnt == 2'b00) timeout("cont_wait");
      gcyc = cyc;
      chk("cont_order", gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k > 0) chk("cont_spacing", gcyc - prev_cyc, 6);
      prev_cyc = gcyc;
    end
    @(posedge clk); #1 req = 2'b00;
    wait_done(lat);
    chk("cont_last_id", done_id, 1);
    // exhaustive sweep through requester 0
    for (int mi = -8; mi < 8; mi++)
      for (int qi = -8; qi < 8; qi++) begin
        run_op(0, W'(mi), W'(qi), lat);
        e = mi * qi;
        chk("sweep_product", product, e[2*W-1:0]);
      end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
